// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Issues one operation at a time to an external multi-cycle ALU,
//               waits the op's settle latency and captures the HI/LO results.
//               Optional macro ALU_SEQ_DIVZERO_EN: short-circuit divide by zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int SINGLE_LAT = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_ra,
    input  logic [31:0] req_rb,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    input  logic [31:0] alu_zhi,
    input  logic [31:0] alu_zlo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        z_valid,
    output logic        illegal,
    output logic        div_zero
);

    localparam logic [4:0] c_OP_NONE = 5'b00000;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_SHR  = 5'b00101;
    localparam logic [4:0] c_OP_SHL  = 5'b00110;
    localparam logic [4:0] c_OP_ROR  = 5'b00111;
    localparam logic [4:0] c_OP_ROL  = 5'b01000;
    localparam logic [4:0] c_OP_AND  = 5'b01001;
    localparam logic [4:0] c_OP_OR   = 5'b01010;
    localparam logic [4:0] c_OP_MUL  = 5'b01110;
    localparam logic [4:0] c_OP_DIV  = 5'b01111;
    localparam logic [4:0] c_OP_NEG  = 5'b10000;
    localparam logic [4:0] c_OP_NOT  = 5'b10001;

    localparam logic [3:0] c_SINGLE_M1 = 4'(SINGLE_LAT - 1);
    localparam logic [3:0] c_MULDIV_M1 = 4'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  alu_opcode_q;
    logic [31:0] alu_ra_q;
    logic [31:0] alu_rb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        ready_q;
    logic        z_valid_q;
    logic        illegal_q;
    logic        div_zero_q;

    logic        w_legal;
    logic        w_req_muldiv;
    logic        w_cap_muldiv;
    logic        w_divzero;

    always_comb begin
        w_legal = 1'b0;
        case (req_op)
            c_OP_ADD, c_OP_SUB, c_OP_SHR, c_OP_SHL, c_OP_ROR, c_OP_ROL,
            c_OP_AND, c_OP_OR,  c_OP_MUL, c_OP_DIV, c_OP_NEG, c_OP_NOT:
                w_legal = 1'b1;
            default:
                w_legal = 1'b0;
        endcase
    end

    assign w_req_muldiv = (req_op == c_OP_MUL) || (req_op == c_OP_DIV);
    // Result width is decided by the op held on the ALU, not the live request.
    assign w_cap_muldiv = (alu_opcode_q == c_OP_MUL) || (alu_opcode_q == c_OP_DIV);

`ifdef ALU_SEQ_DIVZERO_EN
    assign w_divzero = (req_op == c_OP_DIV) && (req_rb == 32'd0);
`else
    assign w_divzero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            alu_opcode_q <= c_OP_NONE;
            alu_ra_q     <= 32'd0;
            alu_rb_q     <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            ready_q      <= 1'b1;
            z_valid_q    <= 1'b0;
            illegal_q    <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ready_q    <= 1'b0;
                        illegal_q  <= 1'b0;
                        div_zero_q <= 1'b0;
                        if (!w_legal) begin
                            illegal_q    <= 1'b1;
                            alu_opcode_q <= c_OP_NONE;
                            z_valid_q    <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (w_divzero) begin
                            div_zero_q   <= 1'b1;
                            alu_opcode_q <= c_OP_NONE;
                            hi_q         <= 32'hFFFF_FFFF;
                            lo_q         <= 32'hFFFF_FFFF;
                            z_valid_q    <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            alu_opcode_q <= req_op;
                            alu_ra_q     <= req_ra;
                            alu_rb_q     <= req_rb;
                            cnt_q        <= w_req_muldiv ? c_MULDIV_M1 : c_SINGLE_M1;
                            state_q      <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (w_cap_muldiv) begin
                            hi_q <= alu_zhi;
                        end
                        lo_q         <= alu_zlo;
                        alu_opcode_q <= c_OP_NONE;
                        z_valid_q    <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    z_valid_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    z_valid_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_ra     = alu_ra_q;
    assign alu_rb     = alu_rb_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign z_valid    = z_valid_q;
    assign illegal    = illegal_q;
    assign div_zero   = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural ALU.
//               Honours macro ALU_SEQ_DIVZERO_EN for divide-by-zero expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam int SL = 1;
    localparam int ML = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_ra, req_rb;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_ra, alu_rb;
    logic [31:0] alu_zhi, alu_zlo;
    logic [31:0] hi_out, lo_out;
    logic        z_valid, illegal, div_zero;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clock = ~clock;

    alu_sequencer #(.SINGLE_LAT(SL), .MULDIV_LAT(ML)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb),
        .alu_opcode(alu_opcode), .alu_ra(alu_ra), .alu_rb(alu_rb),
        .alu_zhi(alu_zhi), .alu_zlo(alu_zlo),
        .hi_out(hi_out), .lo_out(lo_out),
        .z_valid(z_valid), .illegal(illegal), .div_zero(div_zero)
    );

    // Behavioural ALU; zhi carries a junk pattern for single-result ops.
    function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa;
        logic [63:0] t;
        logic [31:0] junk;
        junk = a ^ 32'hDEAD_BEEF;
        aa   = {a, a};
        case (op)
            5'b00011: return {junk, a + b};
            5'b00100: return {junk, a - b};
            5'b00101: return {junk, a >> b[4:0]};
            5'b00110: return {junk, a << b[4:0]};
            5'b00111: begin t = aa >> b[4:0]; return {junk, t[31:0]}; end
            5'b01000: begin t = aa << b[4:0]; return {junk, t[63:32]}; end
            5'b01001: return {junk, a & b};
            5'b01010: return {junk, a | b};
            5'b01110: return {32'd0, a} * {32'd0, b};
            5'b01111: return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            5'b10000: return {junk, -a};
            5'b10001: return {junk, ~a};
            default:  return {junk, 32'h0BAD_0BAD};
        endcase
    endfunction

    always_comb {alu_zhi, alu_zlo} = alu_f(alu_opcode, alu_ra, alu_rb);

    function automatic bit is_legal(input logic [4:0] op);
        return (op >= 5'd3 && op <= 5'd10) || op == 5'd14 || op == 5'd15 || op == 5'd16 || op == 5'd17;
    endfunction

    function automatic bit dz_skip(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_DIVZERO_EN
        return (op == 5'd15) && (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Runs one transaction from an idle cycle and checks it end to end;
    // h* are the values left on the request bus after the accept edge.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] hop, input logic [31:0] ha, input logic [31:0] hb,
                          input logic hvalid);
        logic [63:0] r;
        bit il, dz, md;
        int lat, n;
        r   = alu_f(op, a, b);
        il  = !is_legal(op);
        dz  = !il && dz_skip(op, b);
        md  = (op == 5'd14) || (op == 5'd15);
        lat = (il || dz) ? 0 : (md ? ML : SL);

        nvec++;
        if (req_ready !== 1'b1) begin
            nerr++; $display("FAIL ready_before_issue op=%b: got %b want 1", op, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_ra = a; req_rb = b;
        @(posedge clock); #1;
        req_valid = hvalid; req_op = hop; req_ra = ha; req_rb = hb;

        n = 0;
        while (z_valid !== 1'b1 && n < 40) begin
            nvec++;
            if (req_ready !== 1'b0 || alu_opcode !== op || alu_ra !== a || alu_rb !== b) begin
                nerr++;
                $display("FAIL exec_hold op=%b: got ready=%b opc=%b ra=%h rb=%h want 0 %b %h %h",
                         op, req_ready, alu_opcode, alu_ra, alu_rb, op, a, b);
            end
            @(posedge clock); #1;
            n++;
        end
        nvec++;
        if (n != lat) begin
            nerr++; $display("FAIL latency op=%b: got %0d want %0d", op, n, lat);
        end

        if (dz) begin
            exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFF;
        end else if (!il) begin
            if (md) exp_hi = r[63:32];
            exp_lo = r[31:0];
        end
        nvec++;
        if (hi_out !== exp_hi || lo_out !== exp_lo || illegal !== il || div_zero !== dz ||
            alu_opcode !== 5'd0 || req_ready !== 1'b0) begin
            nerr++;
            $display("FAIL result op=%b a=%h b=%h: got hi=%h lo=%h il=%b dz=%b opc=%b rdy=%b want %h %h %b %b 00000 0",
                     op, a, b, hi_out, lo_out, illegal, div_zero, alu_opcode, req_ready,
                     exp_hi, exp_lo, il, dz);
        end

        @(posedge clock); #1;
        nvec++;
        if (z_valid !== 1'b0 || req_ready !== 1'b1 || illegal !== il || div_zero !== dz ||
            hi_out !== exp_hi || lo_out !== exp_lo) begin
            nerr++;
            $display("FAIL after_done op=%b: got zv=%b rdy=%b il=%b dz=%b hi=%h lo=%h want 0 1 %b %b %h %h",
                     op, z_valid, req_ready, illegal, div_zero, hi_out, lo_out, il, dz, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        clear = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_ra = 32'd0; req_rb = 32'd0;
        repeat (2) begin @(posedge clock); #1; end
        clear = 1'b0;
        nvec++;
        if (req_ready !== 1'b1 || z_valid !== 1'b0 || illegal !== 1'b0 || div_zero !== 1'b0) begin
            nerr++; $display("FAIL reset_flags: got rdy=%b zv=%b il=%b dz=%b want 1 0 0 0",
                             req_ready, z_valid, illegal, div_zero);
        end
        nvec++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0 || alu_opcode !== 5'd0 ||
            alu_ra !== 32'd0 || alu_rb !== 32'd0) begin
            nerr++; $display("FAIL reset_data: got hi=%h lo=%h opc=%b ra=%h rb=%h want all zero",
                             hi_out, lo_out, alu_opcode, alu_ra, alu_rb);
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_add;
        run_op(5'b00011, 32'd5, 32'd7, 5'b00100, 32'h1111, 32'h2222, 1'b0);
        nvec++;
        if (lo_out !== 32'd12 || hi_out !== 32'd0) begin
            nerr++; $display("FAIL add_5_7: got hi=%h lo=%h want 0 0000000c", hi_out, lo_out);
        end
    endtask

    task automatic test_mul;
        run_op(5'b01110, 32'h10000, 32'h10000, 5'b00011, 32'd9, 32'd9, 1'b0);
        nvec++;
        if (hi_out !== 32'd1 || lo_out !== 32'd0) begin
            nerr++; $display("FAIL mul_2p32: got hi=%h lo=%h want 1 0", hi_out, lo_out);
        end
    endtask

    task automatic test_illegal;
        run_op(5'b11111, 32'hAAAA_5555, 32'h1234, 5'd0, 32'd0, 32'd0, 1'b0);
        run_op(5'b01011, 32'h1, 32'h2, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_divzero;
        run_op(5'b01111, 32'd123, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        run_op(5'b01111, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_clear_exec;
        req_valid = 1'b1; req_op = 5'b01111; req_ra = 32'd1000; req_rb = 32'd3;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        nvec++;
        if (z_valid !== 1'b0 || req_ready !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd0 ||
            alu_opcode !== 5'd0 || alu_ra !== 32'd0 || alu_rb !== 32'd0 || illegal !== 1'b0) begin
            nerr++; $display("FAIL clear_exec: got zv=%b rdy=%b hi=%h lo=%h opc=%b ra=%h rb=%h il=%b want 0 1 0 0 0 0 0 0",
                             z_valid, req_ready, hi_out, lo_out, alu_opcode, alu_ra, alu_rb, illegal);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            nvec++;
            if (z_valid !== 1'b0 || lo_out !== 32'd0) begin
                nerr++; $display("FAIL clear_no_pulse: got zv=%b lo=%h want 0 0", z_valid, lo_out);
            end
        end
    endtask

    task automatic test_clear_priority;
        clear = 1'b1; req_valid = 1'b1; req_op = 5'b00011; req_ra = 32'd4; req_rb = 32'd4;
        @(posedge clock); #1;
        clear = 1'b0; req_valid = 1'b0;
        nvec++;
        if (alu_opcode !== 5'd0 || alu_ra !== 32'd0 || req_ready !== 1'b1) begin
            nerr++; $display("FAIL clear_priority: got opc=%b ra=%h rdy=%b want 0 0 1", alu_opcode, alu_ra, req_ready);
        end
        @(posedge clock); #1;
        nvec++;
        if (z_valid !== 1'b0 || lo_out !== 32'd0) begin
            nerr++; $display("FAIL clear_priority_idle: got zv=%b lo=%h want 0 0", z_valid, lo_out);
        end
    endtask

    task automatic test_back_to_back;
        // Sub stays presented through Mul's execution and must only issue afterwards.
        run_op(5'b01110, 32'h0001_0003, 32'h0002_0005, 5'b00100, 32'd50, 32'd8, 1'b1);
        run_op(5'b00100, 32'd50, 32'd8, 5'd0, 32'd0, 32'd0, 1'b0);
        nvec++;
        if (lo_out !== 32'd42) begin
            nerr++; $display("FAIL back_to_back_sub: got lo=%h want 0000002a", lo_out);
        end
    endtask

    task automatic test_random;
        logic [4:0]  ops [12];
        logic [4:0]  op;
        logic [31:0] a, b;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17};
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
            else                           op = ops[$urandom_range(0, 11)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == 5'd15 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 300));
            run_op(op, a, b, 5'($urandom), $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_divzero();
        test_clear_exec();
        test_clear_priority();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
